// File: rtl/filter_seq.sv
// Sequencer between an ADC stream and an external FIR filter: feeds one sample,
// waits for the filter result, decimates results and buffers one for the consumer.
module filter_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int DECIM_W    = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk_out,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] adc_data,
    output logic                  adc_ready,
    output logic                  filt_enable,
    output logic [DATA_WIDTH-1:0] filt_sample,
    input  logic                  filt_done,
    input  logic [DATA_WIDTH-1:0] filt_result,
    input  logic [DECIM_W-1:0]    decim,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic                  timeout_err,
    input  logic                  clr_err,
    output logic                  busy
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FEED = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]         state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [DECIM_W-1:0] dec_cnt;
    logic [DECIM_W-1:0] eff_decim;
    logic [DECIM_W-1:0] group_decim;
    logic               handshake;
    logic               done;
    logic               last;
    logic               emit;
    logic               timeout_hit;
    logic               drop;

    // Reset forces IDLE, so reset is gated in explicitly to keep adc_ready low during it.
    assign adc_ready   = (state == IDLE) && run && !reset;
    assign filt_enable = (state == FEED);
    assign busy        = (state != IDLE);

    assign handshake   = adc_valid && adc_ready;
    assign done        = (state == WAIT) && filt_done;
    // A new group takes its factor from decim; mid-group the latched factor applies.
    assign group_decim = (dec_cnt != '0) ? eff_decim
                       : ((decim == '0) ? DECIM_W'(1) : decim);
    assign last        = (dec_cnt == group_decim - DECIM_W'(1));
    assign emit        = done && last;
    assign drop        = emit && out_valid && !out_ready;
    assign timeout_hit = (state == WAIT) && !filt_done
                       && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (handshake) state <= FEED;
                FEED: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (filt_done || timeout_hit) state <= IDLE;
                    else                          wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            filt_sample <= '0;
            dec_cnt     <= '0;
            eff_decim   <= DECIM_W'(1);
        end else begin
            if (handshake) filt_sample <= adc_data;
            if (done) begin
                if (dec_cnt == '0) eff_decim <= group_decim;
                dec_cnt <= last ? '0 : dec_cnt + DECIM_W'(1);
            end
        end
    end

    // Single-entry output buffer; a result arriving while it is full is dropped.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (emit && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_data  <= filt_result;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flags: a set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (drop)         overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (timeout_hit)  timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_filter_seq.sv
// Directed bench for filter_seq: stimulus pushes expected results into a queue,
// an independent monitor pops them on each output transfer.
module tb_filter_seq;

    localparam int DW = 16;
    localparam int DCW = 4;
    localparam int TO = 8;

    logic          clk_out = 1'b0;
    logic          reset;
    logic          run;
    logic          adc_valid;
    logic [DW-1:0] adc_data;
    logic          adc_ready;
    logic          filt_enable;
    logic [DW-1:0] filt_sample;
    logic          filt_done;
    logic [DW-1:0] filt_result;
    logic [DCW-1:0] decim;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          overrun;
    logic          timeout_err;
    logic          clr_err;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    filter_seq #(.DATA_WIDTH(DW), .DECIM_W(DCW), .TIMEOUT(TO)) dut (
        .clk_out(clk_out), .reset(reset), .run(run),
        .adc_valid(adc_valid), .adc_data(adc_data), .adc_ready(adc_ready),
        .filt_enable(filt_enable), .filt_sample(filt_sample),
        .filt_done(filt_done), .filt_result(filt_result), .decim(decim),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .overrun(overrun), .timeout_err(timeout_err), .clr_err(clr_err),
        .busy(busy)
    );

    always #5 clk_out = ~clk_out;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (adc_ready) break;
            tick();
        end
        check("adc_ready_wait", {31'd0, adc_ready}, 32'd1);
    endtask

    // One sample through FEED and WAIT with filt_done in the first WAIT cycle.
    task automatic do_sample(input logic [DW-1:0] d, input logic [DW-1:0] r,
                             input bit exp_emit, input bit clr_at_done);
        if (exp_emit) exp_q.push_back(r);
        wait_ready();
        adc_valid = 1'b1;
        adc_data  = d;
        tick();
        adc_valid = 1'b0;
        check("feed_enable", {31'd0, filt_enable}, 32'd1);
        check("feed_sample", {16'd0, filt_sample}, {16'd0, d});
        tick();
        check("wait_enable", {31'd0, filt_enable}, 32'd0);
        filt_done   = 1'b1;
        filt_result = r;
        if (clr_at_done) clr_err = 1'b1;
        tick();
        filt_done = 1'b0;
        clr_err   = 1'b0;
    endtask

    always @(negedge clk_out) begin
        if (!reset && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got %h, no result expected", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL out_data: got %h, expected %h", out_data, mon_exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; run = 1'b1; adc_valid = 1'b0; adc_data = '0;
        filt_done = 1'b0; filt_result = '0; decim = 4'd1;
        out_ready = 1'b1; clr_err = 1'b0;
        tick(); tick();

        // Reset values
        check("rst_adc_ready", {31'd0, adc_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_enable", {31'd0, filt_enable}, 32'd0);
        check("rst_sample", {16'd0, filt_sample}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_flags", {30'd0, overrun, timeout_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic latency, decim=1
        do_sample(16'h0010, 16'h0080, 1, 0);
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        check("lat_out_data", {16'd0, out_data}, 32'h0080);
        check("lat_adc_ready", {31'd0, adc_ready}, 32'd1);
        tick();
        check("clear_out_valid", {31'd0, out_valid}, 32'd0);
        filt_done = 1'b1; filt_result = 16'hBEEF;
        tick();
        filt_done = 1'b0;
        check("idle_done_ignored", {31'd0, out_valid}, 32'd0);

        // decim=4: emits after 4th and 8th done
        decim = 4'd4;
        for (int i = 1; i <= 8; i++) begin
            do_sample(16'(16'h0100 + i), 16'(16'h1000 + i), (i % 4) == 0, 0);
            if (i == 1) check("dec4_no_emit", {31'd0, out_valid}, 32'd0);
        end
        // decim=0 treated as 1
        decim = 4'd0;
        for (int i = 1; i <= 3; i++) do_sample(16'(16'h0200 + i), 16'(16'h2000 + i), 1, 0);
        decim = 4'd1;
        tick();

        // Overrun: first held, second dropped
        out_ready = 1'b0;
        do_sample(16'h00A1, 16'h0A11, 1, 0);
        do_sample(16'h00B2, 16'h0B22, 0, 0);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check("ovr_held", {16'd0, out_data}, 32'h0A11);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);
        do_sample(16'h00C3, 16'h0C33, 0, 1);
        check("ovr_set_wins", {31'd0, overrun}, 32'd1);
        check("ovr_still_held", {16'd0, out_data}, 32'h0A11);
        out_ready = 1'b1;
        tick();
        check("ovr_drained", {31'd0, out_valid}, 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Timeout with decim=2: count survives the timed-out sample
        decim = 4'd2;
        do_sample(16'h0021, 16'h0210, 0, 0);
        wait_ready();
        adc_valid = 1'b1; adc_data = 16'h0022;
        tick();
        adc_valid = 1'b0;
        tick();
        repeat (TO - 1) tick();
        check("to_not_yet", {31'd0, timeout_err}, 32'd0);
        check("to_busy", {31'd0, busy}, 32'd1);
        tick();
        check("to_set", {31'd0, timeout_err}, 32'd1);
        check("to_idle", {31'd0, busy}, 32'd0);
        check("to_adc_ready", {31'd0, adc_ready}, 32'd1);
        decim = 4'd5;
        do_sample(16'h0023, 16'h0230, 1, 0);
        decim = 4'd1;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("to_cleared", {31'd0, timeout_err}, 32'd0);

        // Reset during WAIT abandons the operation
        wait_ready();
        adc_valid = 1'b1; adc_data = 16'h0055;
        tick();
        adc_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("rw_busy", {31'd0, busy}, 32'd0);
        check("rw_adc_ready", {31'd0, adc_ready}, 32'd0);
        tick();
        reset = 1'b0;
        filt_done = 1'b1; filt_result = 16'hDEAD;
        tick();
        filt_done = 1'b0;
        check("rw_out_valid", {31'd0, out_valid}, 32'd0);
        check("rw_out_data", {16'd0, out_data}, 32'd0);
        check("rw_sample", {16'd0, filt_sample}, 32'd0);
        check("rw_flags", {30'd0, overrun, timeout_err}, 32'd0);

        // run=0 mid-WAIT: in-flight result still emitted
        wait_ready();
        exp_q.push_back(16'h0C0C);
        adc_valid = 1'b1; adc_data = 16'h0066;
        tick();
        adc_valid = 1'b0;
        tick();
        run = 1'b0;
        filt_done = 1'b1; filt_result = 16'h0C0C;
        tick();
        filt_done = 1'b0;
        check("run0_emit", {31'd0, out_valid}, 32'd1);
        check("run0_no_ready", {31'd0, adc_ready}, 32'd0);
        tick(); tick();
        check("run0_still_no_ready", {31'd0, adc_ready}, 32'd0);
        check("run0_idle", {31'd0, busy}, 32'd0);

        tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_seq.md
FILTER_SEQ -- requirements
Module: filter_seq

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the width of sample and result data.
REQ-002 The block SHALL have parameter DECIM_W, default 4, giving the width of the decimation factor.
REQ-003 The block SHALL have parameter TIMEOUT, default 8, giving the maximum number of WAIT cycles before filt_done is considered missing.

Interface
REQ-004 clk_out  input  1  block clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 run  input  1  high permits new sample acceptance.
REQ-007 adc_valid  input  1  ADC sample available.
REQ-008 adc_data  input  DATA_WIDTH  ADC sample.
REQ-009 adc_ready  output  1  block accepts a sample this cycle.
REQ-010 filt_enable  output  1  one-cycle strobe to the FIR filter.
REQ-011 filt_sample  output  DATA_WIDTH  sample presented to the FIR filter.
REQ-012 filt_done  input  1  FIR done strobe.
REQ-013 filt_result  input  DATA_WIDTH  FIR output, valid when filt_done is high.
REQ-014 decim  input  DECIM_W  decimation factor; 0 is treated as 1.
REQ-015 out_valid  output  1  decimated result available.
REQ-016 out_data  output  DATA_WIDTH  decimated result.
REQ-017 out_ready  input  1  consumer accepts out_data.
REQ-018 overrun  output  1  sticky flag: a result was dropped.
REQ-019 timeout_err  output  1  sticky flag: filt_done was missing.
REQ-020 clr_err  input  1  clears overrun and timeout_err.
REQ-021 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, FEED and WAIT, and SHALL generate all outputs as registered or Moore outputs.
REQ-023 adc_ready SHALL equal (state==IDLE and run); a handshake occurs when adc_valid and adc_ready are both high.
REQ-024 On a handshake, adc_data SHALL be captured into filt_sample and the FSM SHALL go IDLE->FEED.
REQ-025 In FEED, filt_enable SHALL be 1 for exactly one cycle, and the FSM SHALL go to WAIT unconditionally.
REQ-026 filt_enable SHALL be 0 in all states other than FEED.
REQ-027 filt_sample SHALL hold its value until the next handshake.
REQ-028 In WAIT with filt_done=1, the FSM SHALL take the done action (REQ-030 to REQ-032) and return to IDLE.
REQ-029 If WAIT lasts TIMEOUT cycles without filt_done, timeout_err SHALL be set, the FSM SHALL return to IDLE, and the decimation count SHALL be unchanged.
REQ-030 The done action SHALL advance a decimation counter (width DECIM_W).
REQ-031 When the counter equals eff_decim-1, the done action SHALL emit filt_result and reset the counter to 0; otherwise it SHALL increment the counter and emit nothing.
REQ-032 eff_decim SHALL be latched from decim (0 mapped to 1) when the counter is 0 and a done action occurs; decim changes mid-group SHALL be ignored.
REQ-033 Emit with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle, SHALL load out_data and set out_valid=1 with no overrun.
REQ-034 Emit with out_valid=1 and out_ready=0 SHALL keep the old out_data, drop the new result and set overrun.
REQ-035 out_valid SHALL clear after an out_valid&out_ready cycle that has no simultaneous emit.
REQ-036 out_data SHALL be stable while out_valid=1.
REQ-037 Latency: a handshake in cycle 0 SHALL give filt_enable=1 in cycle 1, filt_done expected in cycle 2, out_valid=1 in cycle 3 (decim=1), and adc_ready=1 again in cycle 3.
REQ-038 Throughput SHALL be at most one sample per 3 cycles.
REQ-039 run=0 SHALL block new handshakes only; an in-flight FEED/WAIT sequence SHALL complete normally.
REQ-040 filt_done outside WAIT SHALL be ignored.
REQ-041 clr_err SHALL clear both sticky flags; if a set condition occurs in the same cycle, set SHALL win.

Reset
REQ-042 reset=1 SHALL asynchronously force state=IDLE, decimation counter=0, eff_decim=1, filt_enable=0, filt_sample=0, out_valid=0, out_data=0, overrun=0, timeout_err=0 and busy=0.
REQ-043 Reset during FEED or WAIT SHALL abandon the operation, with no emit and no flag set.
REQ-044 adc_ready SHALL be 0 during reset.

Verification
REQ-045 decim=1, run=1, adc_data=0x0010 accepted in cycle 0, filter model returns 0x0080 with done in cycle 2 -> filt_enable high only in cycle 1, out_valid=1 and out_data=0x0080 in cycle 3.
REQ-046 decim=4, 8 back-to-back samples, out_ready=1 -> exactly 2 emits, after the 4th and 8th done, carrying those cycles' filt_result; decim=0 -> one emit per sample.
REQ-047 out_ready=0, decim=1, two samples -> first result held, second dropped, overrun=1; clr_err pulse -> overrun=0; clr_err coincident with a third drop -> overrun stays 1.
REQ-048 Filter model never asserts done -> timeout_err=1 exactly TIMEOUT cycles after entering WAIT, FSM in IDLE, adc_ready=1 again.
REQ-049 Reset asserted in WAIT and filt_done pulsed after release -> no out_valid, all outputs at reset values; run=0 mid-WAIT -> in-flight result still emitted, no further adc_ready.
